// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory arbiter slice.
package imem_pkg;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } imem_state_t;

   localparam int unsigned IMEM_ADDR_W = 6;
   localparam int unsigned IMEM_DATA_W = 32;

   // ADDI x0,x0,0
   localparam logic [31:0] RV_NOP = 32'h00000013;

endpackage

// File: rtl/imem_rr_hold.sv
// Loader starvation guard: counts consecutive fetch grants that a pending
// loader write has lost, and forces the loader through at MAX_HOLD.
module imem_rr_hold
   import imem_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ldr_valid,
   input  logic fetch_gnt,
   input  logic ldr_gnt,
   output logic force_ldr
);

   logic [3:0] hold_cnt;

   // Count fetch wins against a waiting loader; clear when the loader is served or withdraws.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt <= '0;
      end else if (!ldr_valid || ldr_gnt) begin
         hold_cnt <= '0;
      end else if (fetch_gnt) begin
         hold_cnt <= hold_cnt + 4'd1;
      end
   end

   // Loader takes priority once it has lost MAX_HOLD times in a row.
   always_comb begin
      force_ldr = (hold_cnt == 4'(MAX_HOLD));
   end

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter: boot-time loader ownership, then
// fetch-priority arbitration with bounded loader starvation at run time.
module imem_arbiter
   import imem_pkg::*;
#(
   parameter int unsigned ADDR_W   = IMEM_ADDR_W,
   parameter int unsigned DATA_W   = IMEM_DATA_W,
   parameter int unsigned MAX_HOLD = 4,
   parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(RV_NOP)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req_i,
   input  logic [31:0]       cpu_addr_i,
   output logic              cpu_gnt_o,
   output logic              cpu_rvalid_o,
   output logic [DATA_W-1:0] cpu_rdata_o,
   output logic              cpu_err_o,
   output logic              cpu_run_o,
   input  logic              ldr_valid_i,
   input  logic [ADDR_W-1:0] ldr_addr_i,
   input  logic [DATA_W-1:0] ldr_wdata_i,
   output logic              ldr_ready_o,
   input  logic              ldr_done_i,
   output logic [ADDR_W:0]   ldr_count_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   localparam logic [ADDR_W:0] COUNT_FULL = {1'b1, {ADDR_W{1'b0}}};

   imem_state_t       state;
   logic              force_ldr;
   logic              fault;
   logic              ldr_acc;
   logic [ADDR_W-1:0] fetch_idx;

   imem_rr_hold #(
      .MAX_HOLD (MAX_HOLD)
   ) u_hold (
      .clk       (clk),
      .rst_n     (rst_n),
      .ldr_valid (ldr_valid_i),
      .fetch_gnt (cpu_gnt_o),
      .ldr_gnt   (ldr_acc),
      .force_ldr (force_ldr)
   );

   // Arbitration and memory port steering; port is idle while in reset.
   always_comb begin
      fetch_idx = cpu_addr_i[ADDR_W+1:2];
      fault     = (cpu_addr_i[1:0] != 2'b00) || (|cpu_addr_i[31:ADDR_W+2]);
      if (state == BOOT) begin
         ldr_ready_o = 1'b1;
         cpu_gnt_o   = 1'b0;
      end else begin
         ldr_ready_o = !cpu_req_i || force_ldr;
         cpu_gnt_o   = cpu_req_i && !(ldr_valid_i && ldr_ready_o);
      end
      ldr_acc     = ldr_valid_i && ldr_ready_o;
      mem_en_o    = rst_n && (ldr_acc || (cpu_gnt_o && !fault));
      mem_we_o    = rst_n && ldr_acc;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (rst_n) begin
         mem_addr_o  = ldr_acc ? ldr_addr_i : fetch_idx;
         mem_wdata_o = ldr_acc ? ldr_wdata_i : '0;
      end
   end

   // Boot/run FSM with registered core enable; done is only honoured in BOOT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= BOOT;
         cpu_run_o <= 1'b0;
      end else begin
         case (state)
            BOOT: begin
               if (ldr_done_i) begin
                  state     <= RUN;
                  cpu_run_o <= 1'b1;
               end
            end
            RUN: begin
               state     <= RUN;
               cpu_run_o <= 1'b1;
            end
            default: begin
               state     <= BOOT;
               cpu_run_o <= 1'b0;
            end
         endcase
      end
   end

   // Fetch response flags, one cycle behind the grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cpu_rvalid_o <= 1'b0;
         cpu_err_o    <= 1'b0;
      end else begin
         cpu_rvalid_o <= cpu_gnt_o;
         cpu_err_o    <= cpu_gnt_o && fault;
      end
   end

   // Response data comes straight from the memory's output register.
   always_comb begin
      cpu_rdata_o = '0;
      if (cpu_rvalid_o) begin
         cpu_rdata_o = cpu_err_o ? NOP_WORD : mem_rdata_i;
      end
   end

   // Saturating count of accepted loader writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ldr_count_o <= '0;
      end else if (ldr_acc && (ldr_count_o != COUNT_FULL)) begin
         ldr_count_o <= ldr_count_o + 1'b1;
      end
   end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with an external 1-cycle-latency memory model.
module tb_imem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_req;
   logic [31:0] cpu_addr;
   logic        ldr_valid;
   logic [5:0]  ldr_addr;
   logic [31:0] ldr_wdata;
   logic        ldr_done;

   logic        cpu_gnt, cpu_rvalid, cpu_err, cpu_run, ldr_ready;
   logic [31:0] cpu_rdata;
   logic [6:0]  ldr_count;
   logic        mem_en, mem_we;
   logic [5:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;

   logic        d1_gnt, d1_rvalid, d1_err, d1_run, d1_ready;
   logic [31:0] d1_rdata;
   logic [6:0]  d1_count;
   logic        d1_mem_en, d1_mem_we;
   logic [5:0]  d1_mem_addr;
   logic [31:0] d1_mem_wdata;

   logic [31:0] mem [0:63];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   imem_arbiter #(.ADDR_W(6), .DATA_W(32), .MAX_HOLD(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req_i(cpu_req), .cpu_addr_i(cpu_addr), .cpu_gnt_o(cpu_gnt),
      .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata), .cpu_err_o(cpu_err),
      .cpu_run_o(cpu_run),
      .ldr_valid_i(ldr_valid), .ldr_addr_i(ldr_addr), .ldr_wdata_i(ldr_wdata),
      .ldr_ready_o(ldr_ready), .ldr_done_i(ldr_done), .ldr_count_o(ldr_count),
      .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
   );

   imem_arbiter #(.ADDR_W(6), .DATA_W(32), .MAX_HOLD(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .cpu_req_i(cpu_req), .cpu_addr_i(cpu_addr), .cpu_gnt_o(d1_gnt),
      .cpu_rvalid_o(d1_rvalid), .cpu_rdata_o(d1_rdata), .cpu_err_o(d1_err),
      .cpu_run_o(d1_run),
      .ldr_valid_i(ldr_valid), .ldr_addr_i(ldr_addr), .ldr_wdata_i(ldr_wdata),
      .ldr_ready_o(d1_ready), .ldr_done_i(ldr_done), .ldr_count_o(d1_count),
      .mem_en_o(d1_mem_en), .mem_we_o(d1_mem_we), .mem_addr_o(d1_mem_addr),
      .mem_wdata_o(d1_mem_wdata), .mem_rdata_i(32'h0)
   );

   // Synchronous single-port memory, registered read.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   function automatic logic [31:0] boot_word(input int i);
      case (i)
         0:       boot_word = 32'h00500113;
         1:       boot_word = 32'h00300193;
         2:       boot_word = 32'h00318233;
         default: boot_word = 32'h0AB00000 | 32'(i);
      endcase
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cpu_req   = 1'b0;
      cpu_addr  = 32'h0;
      ldr_valid = 1'b0;
      ldr_addr  = 6'd0;
      ldr_wdata = 32'h0;
      ldr_done  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      ldr_valid = 1'b1;
      ldr_addr  = 6'd9;
      ldr_wdata = 32'hFFFFFFFF;
      #1;
      checks++;
      if (cpu_rvalid !== 1'b0 || cpu_run !== 1'b0 || ldr_count !== 7'd0 || cpu_err !== 1'b0 || cpu_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_state: rvalid=%b run=%b count=%0d err=%b rdata=%h, want 0", cpu_rvalid, cpu_run, ldr_count, cpu_err, cpu_rdata);
      end
      checks++;
      if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 6'd0 || mem_wdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_mem_idle: en=%b we=%b addr=%0d wdata=%h, want all 0", mem_en, mem_we, mem_addr, mem_wdata);
      end
      next_cycle();
      idle_inputs();
      rst_n = 1'b1;
   endtask

   task automatic test_boot();
      for (int i = 0; i < 18; i++) begin
         ldr_valid = 1'b1;
         ldr_addr  = 6'(i);
         ldr_wdata = boot_word(i);
         cpu_req   = (i != 17);
         cpu_addr  = 32'h0;
         ldr_done  = (i == 17);
         #1;
         checks++;
         if (cpu_gnt !== 1'b0 || ldr_ready !== 1'b1 || cpu_run !== 1'b0) begin
            errors++;
            $display("FAIL boot_gnt i=%0d: gnt=%b ready=%b run=%b, want 0 1 0", i, cpu_gnt, ldr_ready, cpu_run);
         end
         checks++;
         if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 6'(i) || mem_wdata !== boot_word(i)) begin
            errors++;
            $display("FAIL boot_write i=%0d: en=%b we=%b addr=%0d wdata=%h, want 1 1 %0d %h", i, mem_en, mem_we, mem_addr, mem_wdata, i, boot_word(i));
         end
         next_cycle();
      end
      idle_inputs();
      checks++;
      if (cpu_run !== 1'b1 || ldr_count !== 7'd18) begin
         errors++;
         $display("FAIL boot_done: run=%b count=%0d, want 1 18", cpu_run, ldr_count);
      end
   endtask

   task automatic test_fetch_stream();
      logic [31:0] exp_d [0:2];
      exp_d[0] = 32'h00500113;
      exp_d[1] = 32'h00300193;
      exp_d[2] = 32'h00318233;
      for (int k = 0; k < 4; k++) begin
         cpu_req  = (k < 3);
         cpu_addr = 32'(4 * k);
         #1;
         if (k < 3) begin
            checks++;
            if (cpu_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 6'(k)) begin
               errors++;
               $display("FAIL stream_gnt k=%0d: gnt=%b en=%b we=%b addr=%0d, want 1 1 0 %0d", k, cpu_gnt, mem_en, mem_we, mem_addr, k);
            end
         end
         if (k > 0) begin
            checks++;
            if (cpu_rvalid !== 1'b1 || cpu_err !== 1'b0 || cpu_rdata !== exp_d[k-1]) begin
               errors++;
               $display("FAIL stream_rsp k=%0d: rvalid=%b err=%b data=%h, want 1 0 %h", k, cpu_rvalid, cpu_err, cpu_rdata, exp_d[k-1]);
            end
         end
         next_cycle();
      end
      idle_inputs();
      checks++;
      if (cpu_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL stream_idle: rvalid=%b, want 0", cpu_rvalid);
      end
   endtask

   task automatic test_faults();
      logic [31:0] addrs [0:1];
      addrs[0] = 32'h00000002;
      addrs[1] = 32'h00000100;
      for (int k = 0; k < 3; k++) begin
         cpu_req  = (k < 2);
         cpu_addr = (k < 2) ? addrs[k] : 32'h0;
         #1;
         if (k < 2) begin
            checks++;
            if (cpu_gnt !== 1'b1 || mem_en !== 1'b0) begin
               errors++;
               $display("FAIL fault_gnt a=%h: gnt=%b en=%b, want 1 0", addrs[k], cpu_gnt, mem_en);
            end
         end
         if (k > 0) begin
            checks++;
            if (cpu_rvalid !== 1'b1 || cpu_err !== 1'b1 || cpu_rdata !== 32'h00000013) begin
               errors++;
               $display("FAIL fault_rsp a=%h: rvalid=%b err=%b data=%h, want 1 1 00000013", addrs[k-1], cpu_rvalid, cpu_err, cpu_rdata);
            end
         end
         next_cycle();
      end
      idle_inputs();
   endtask

   task automatic test_starvation();
      cpu_req   = 1'b1;
      cpu_addr  = 32'h0;
      ldr_valid = 1'b1;
      ldr_addr  = 6'd5;
      ldr_wdata = 32'h55555555;
      for (int c = 1; c <= 6; c++) begin
         #1;
         checks++;
         if (ldr_ready !== (c == 5) || cpu_gnt !== (c != 5)) begin
            errors++;
            $display("FAIL starve_hold4 c=%0d: ready=%b gnt=%b, want %b %b", c, ldr_ready, cpu_gnt, (c == 5), (c != 5));
         end
         checks++;
         if (d1_ready !== (c % 2 == 0) || d1_gnt !== (c % 2 == 1)) begin
            errors++;
            $display("FAIL starve_hold1 c=%0d: ready=%b gnt=%b, want %b %b", c, d1_ready, d1_gnt, (c % 2 == 0), (c % 2 == 1));
         end
         if (c == 5) begin
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== 6'd5) begin
               errors++;
               $display("FAIL starve_write: we=%b addr=%0d, want 1 5", mem_we, mem_addr);
            end
         end
         next_cycle();
      end
      idle_inputs();
      checks++;
      if (ldr_count !== 7'd19 || d1_count !== 7'd21) begin
         errors++;
         $display("FAIL starve_count: hold4=%0d hold1=%0d, want 19 21", ldr_count, d1_count);
      end
   endtask

   task automatic test_reset_mid();
      cpu_req  = 1'b1;
      cpu_addr = 32'h4;
      #1;
      checks++;
      if (cpu_gnt !== 1'b1) begin
         errors++;
         $display("FAIL midrst_gnt: gnt=%b, want 1", cpu_gnt);
      end
      next_cycle();
      cpu_req  = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (cpu_rvalid !== 1'b0 || cpu_run !== 1'b0 || ldr_count !== 7'd0 || ldr_ready !== 1'b1 || cpu_gnt !== 1'b0) begin
         errors++;
         $display("FAIL midrst_state: rvalid=%b run=%b count=%0d ready=%b gnt=%b, want 0 0 0 1 0", cpu_rvalid, cpu_run, ldr_count, ldr_ready, cpu_gnt);
      end
      next_cycle();
      rst_n = 1'b1;
      for (int c = 0; c < 2; c++) begin
         next_cycle();
         checks++;
         if (cpu_rvalid !== 1'b0 || cpu_run !== 1'b0) begin
            errors++;
            $display("FAIL midrst_stale c=%0d: rvalid=%b run=%b, want 0 0", c, cpu_rvalid, cpu_run);
         end
      end
      ldr_done = 1'b1;
      next_cycle();
      ldr_done = 1'b0;
      checks++;
      if (cpu_run !== 1'b1 || ldr_count !== 7'd0) begin
         errors++;
         $display("FAIL reboot: run=%b count=%0d, want 1 0", cpu_run, ldr_count);
      end
   endtask

   task automatic test_overlap();
      cpu_req  = 1'b1;
      cpu_addr = 32'd12;
      #1;
      checks++;
      if (cpu_gnt !== 1'b1) begin
         errors++;
         $display("FAIL overlap_gnt1: gnt=%b, want 1", cpu_gnt);
      end
      next_cycle();
      cpu_req   = 1'b0;
      ldr_valid = 1'b1;
      ldr_addr  = 6'd3;
      ldr_wdata = 32'hDEAD0003;
      #1;
      checks++;
      if (ldr_ready !== 1'b1 || cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h0AB00003) begin
         errors++;
         $display("FAIL overlap_old: ready=%b rvalid=%b data=%h, want 1 1 0ab00003", ldr_ready, cpu_rvalid, cpu_rdata);
      end
      next_cycle();
      ldr_valid = 1'b0;
      cpu_req   = 1'b1;
      cpu_addr  = 32'd12;
      next_cycle();
      cpu_req = 1'b0;
      #1;
      checks++;
      if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEAD0003 || ldr_count !== 7'd1) begin
         errors++;
         $display("FAIL overlap_new: rvalid=%b data=%h count=%0d, want 1 dead0003 1", cpu_rvalid, cpu_rdata, ldr_count);
      end
      next_cycle();
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 70; i++) begin
         ldr_valid = 1'b1;
         ldr_addr  = 6'(i);
         ldr_wdata = 32'(i);
         next_cycle();
         if (i == 61) begin
            checks++;
            if (ldr_count !== 7'd63) begin
               errors++;
               $display("FAIL sat_pre: count=%0d, want 63", ldr_count);
            end
         end
         if (i == 62) begin
            checks++;
            if (ldr_count !== 7'd64) begin
               errors++;
               $display("FAIL sat_reach: count=%0d, want 64", ldr_count);
            end
         end
      end
      idle_inputs();
      checks++;
      if (ldr_count !== 7'd64 || d1_count !== 7'd64) begin
         errors++;
         $display("FAIL sat_stick: count=%0d d1=%0d, want 64 64", ldr_count, d1_count);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_boot();
      test_fetch_stream();
      test_faults();
      test_starvation();
      test_reset_mid();
      test_overlap();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
